// File: rtl/pc_ir_fetch_pkg.sv
// Shared definitions for the PC/IR fetch unit: default widths, timeout and FSM encoding.
// Imported by the interface and the top-level fetch module.
package pc_ir_fetch_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INST_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_FAULT   = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/pc_ir_fetch_if.sv
// Controller, data-port, memory-bank and status signals of the fetch unit.
// master is the fetch unit's view; slave is the controller/memory side.
interface pc_ir_fetch_if
  import pc_ir_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF
);

  logic              pc_clear;
  logic              pc_load;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc_load_addr;
  logic              ir_load;

  logic              mb_sel;
  logic              mb_read;
  logic              mb_write;
  logic [ADDR_W-1:0] mb_addr;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [INST_W-1:0] mem_rdata;
  logic              mem_ready;

  logic [INST_W-1:0] ir_inst;
  logic [ADDR_W-1:0] pc;
  logic              fetch_busy;
  logic              fetch_done;
  logic              fetch_err;

  modport master (
    input  pc_clear, pc_load, pc_inc, pc_load_addr, ir_load,
    input  mb_sel, mb_read, mb_write, mb_addr,
    input  mem_rdata, mem_ready,
    output mem_addr, mem_rd, mem_wr,
    output ir_inst, pc, fetch_busy, fetch_done, fetch_err
  );

  modport slave (
    output pc_clear, pc_load, pc_inc, pc_load_addr, ir_load,
    output mb_sel, mb_read, mb_write, mb_addr,
    output mem_rdata, mem_ready,
    input  mem_addr, mem_rd, mem_wr,
    input  ir_inst, pc, fetch_busy, fetch_done, fetch_err
  );

endinterface

// File: rtl/pc_ir_fetch_rise_detect.sv
// One-bit 0->1 detector: rise is high while d is 1 and its registered prior value is 0.
// Combinational output, no added latency; the prior-value flop clears on reset.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/pc_ir_fetch.sv
// Program counter plus instruction-register fetch FSM sharing one memory port with a data port.
// ir_load rise to fetch_done is 3 cycles minimum; waits on mem_ready up to TIMEOUT cycles, then faults.
module pc_ir_fetch
  import pc_ir_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INST_W  = INST_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic           CLK100MHZ,
  input logic           rst,
  pc_ir_fetch_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic              err_q, err_d;
  logic              pend_q, pend_d;

  logic ir_rise;
  logic inc_rise;
  logic fetch_start;
  logic inc_req;

  rise_detect u_ir_rise (
    .clk  (CLK100MHZ),
    .rst  (rst),
    .d    (bus.ir_load),
    .rise (ir_rise)
  );

  rise_detect u_inc_rise (
    .clk  (CLK100MHZ),
    .rst  (rst),
    .d    (bus.pc_inc),
    .rise (inc_rise)
  );

  // cnt holds the 1-based index of the current WAIT cycle, so the TIMEOUT-th
  // WAIT cycle still honours mem_ready before falling into FAULT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ir_d        = ir_q;
    err_d       = err_q;
    fetch_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (ir_rise) begin
          state_d     = ST_REQ;
          fetch_start = 1'b1;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
        cnt_d   = CNT_W'(1);
      end
      ST_WAIT: begin
        if (bus.mem_ready) begin
          state_d = ST_CAPTURE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = ST_FAULT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        // Memory keeps read data valid through the capture cycle.
        ir_d    = bus.mem_rdata;
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Increments are held back while the FSM presents pc on the memory port.
  always_comb begin
    pc_d    = pc_q;
    inc_req = pend_q | inc_rise;
    pend_d  = inc_req;
    if (bus.pc_clear) begin
      pc_d   = '0;
      pend_d = 1'b0;
    end else if (bus.pc_load) begin
      pc_d   = bus.pc_load_addr;
      pend_d = 1'b0;
    end else if (inc_req && (state_q == ST_IDLE) && !fetch_start) begin
      pc_d   = pc_q + 1'b1;
      pend_d = 1'b0;
    end
  end

  always_comb begin
    bus.mem_addr = pc_q;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.mem_addr = bus.mb_sel ? bus.mb_addr : pc_q;
        bus.mem_rd   = bus.mb_read;
        bus.mem_wr   = bus.mb_write & bus.mb_sel;
      end
      ST_REQ, ST_WAIT: begin
        bus.mem_rd = 1'b1;
      end
      default: begin
        bus.mem_rd = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.ir_inst    = ir_q;
  assign bus.fetch_busy = (state_q != ST_IDLE);
  assign bus.fetch_done = (state_q == ST_CAPTURE);
  assign bus.fetch_err  = err_q;

endmodule

// File: tb/tb_pc_ir_fetch.sv
// Directed bench for pc_ir_fetch: a per-cycle vector table followed by multi-cycle fetch sequences.
module tb_pc_ir_fetch;

  localparam int AW = 8;
  localparam int IW = 16;
  localparam int NV = 24;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pc_ir_fetch_if #(.ADDR_W(AW), .INST_W(IW)) bus ();

  pc_ir_fetch #(.ADDR_W(AW), .INST_W(IW), .TIMEOUT(15)) dut (
    .CLK100MHZ (clk),
    .rst       (rst),
    .bus       (bus)
  );

  logic [IW-1:0] mem [256];
  assign bus.mem_rdata = mem[bus.mem_addr];

  typedef struct {
    int rst; int clr; int ld; int inc; int ld_addr;
    int ir; int sel; int rd; int wr; int mb_addr; int rdy;
    int e_pc; int e_addr; int e_rd; int e_wr; int e_busy; int e_done; int e_err; int e_ir;
  } vec_t;

  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rst              = 1'b0;
    bus.pc_clear     = 1'b0;
    bus.pc_load      = 1'b0;
    bus.pc_inc       = 1'b0;
    bus.pc_load_addr = '0;
    bus.ir_load      = 1'b0;
    bus.mb_sel       = 1'b0;
    bus.mb_read      = 1'b0;
    bus.mb_write     = 1'b0;
    bus.mb_addr      = '0;
    bus.mem_ready    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int done_cnt, done_k, ir_chg, err_k, idle_k;
    logic [IW-1:0] prev_ir;

    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    mem[8'h00] = 16'h8105;
    mem[8'h01] = 16'h1234;
    mem[8'h10] = 16'hBEEF;
    mem[8'h22] = 16'h5A5A;

    clear_inputs();
    rst = 1'b1;

    //          rst clr ld inc ldad  ir sel rd wr mbad  rdy | pc    addr  rd wr bsy dn er ir
    vecs[0]  = '{1, 0, 0, 0, 0,     0, 0, 0, 0, 0,    0,   0,    0,    0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0,     1, 0, 0, 0, 0,    0,   0,    0,    1, 0, 1, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0,     1, 0, 0, 0, 0,    0,   0,    0,    1, 0, 1, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0,     1, 0, 0, 0, 0,    1,   0,    0,    0, 0, 1, 1, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 0,     1, 0, 0, 0, 0,    0,   0,    0,    0, 0, 0, 0, 0, 'h8105};
    vecs[5]  = '{0, 0, 0, 0, 0,     1, 0, 0, 0, 0,    0,   0,    0,    0, 0, 0, 0, 0, 'h8105};
    vecs[6]  = '{0, 0, 0, 1, 0,     0, 0, 0, 0, 0,    0,   1,    1,    0, 0, 0, 0, 0, 'h8105};
    vecs[7]  = '{0, 0, 0, 0, 0,     1, 1, 0, 1, 'h20, 0,   1,    1,    1, 0, 1, 0, 0, 'h8105};
    vecs[8]  = '{0, 0, 0, 0, 0,     1, 1, 0, 1, 'h20, 0,   1,    1,    1, 0, 1, 0, 0, 'h8105};
    vecs[9]  = '{0, 0, 0, 0, 0,     1, 1, 0, 1, 'h20, 1,   1,    1,    0, 0, 1, 1, 0, 'h8105};
    vecs[10] = '{0, 0, 0, 0, 0,     1, 1, 0, 1, 'h20, 0,   1,    'h20, 0, 1, 0, 0, 0, 'h1234};
    vecs[11] = '{0, 0, 0, 0, 0,     0, 0, 0, 0, 0,    0,   1,    1,    0, 0, 0, 0, 0, 'h1234};
    vecs[12] = '{0, 0, 0, 1, 0,     1, 0, 0, 0, 0,    0,   1,    1,    1, 0, 1, 0, 0, 'h1234};
    vecs[13] = '{0, 0, 0, 1, 0,     1, 0, 0, 0, 0,    0,   1,    1,    1, 0, 1, 0, 0, 'h1234};
    vecs[14] = '{0, 0, 0, 1, 0,     1, 0, 0, 0, 0,    1,   1,    1,    0, 0, 1, 1, 0, 'h1234};
    vecs[15] = '{0, 0, 0, 1, 0,     1, 0, 0, 0, 0,    0,   1,    1,    0, 0, 0, 0, 0, 'h1234};
    vecs[16] = '{0, 0, 0, 0, 0,     0, 0, 0, 0, 0,    0,   2,    2,    0, 0, 0, 0, 0, 'h1234};
    vecs[17] = '{0, 0, 1, 0, 'hFF,  0, 0, 0, 0, 0,    0,   'hFF, 'hFF, 0, 0, 0, 0, 0, 'h1234};
    vecs[18] = '{0, 0, 0, 1, 0,     0, 0, 0, 0, 0,    0,   0,    0,    0, 0, 0, 0, 0, 'h1234};
    vecs[19] = '{0, 0, 1, 0, 'h55,  0, 0, 0, 0, 0,    0,   'h55, 'h55, 0, 0, 0, 0, 0, 'h1234};
    vecs[20] = '{0, 1, 1, 0, 'h40,  0, 0, 0, 0, 0,    0,   0,    0,    0, 0, 0, 0, 0, 'h1234};
    vecs[21] = '{0, 0, 1, 1, 'h10,  0, 0, 0, 0, 0,    0,   'h10, 'h10, 0, 0, 0, 0, 0, 'h1234};
    vecs[22] = '{0, 0, 0, 1, 0,     0, 0, 0, 0, 0,    0,   'h10, 'h10, 0, 0, 0, 0, 0, 'h1234};
    vecs[23] = '{0, 0, 0, 0, 0,     0, 0, 1, 0, 0,    0,   'h10, 'h10, 1, 0, 0, 0, 0, 'h1234};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst              = vecs[i].rst[0];
      bus.pc_clear     = vecs[i].clr[0];
      bus.pc_load      = vecs[i].ld[0];
      bus.pc_inc       = vecs[i].inc[0];
      bus.pc_load_addr = vecs[i].ld_addr[AW-1:0];
      bus.ir_load      = vecs[i].ir[0];
      bus.mb_sel       = vecs[i].sel[0];
      bus.mb_read      = vecs[i].rd[0];
      bus.mb_write     = vecs[i].wr[0];
      bus.mb_addr      = vecs[i].mb_addr[AW-1:0];
      bus.mem_ready    = vecs[i].rdy[0];
      step();
      check($sformatf("v%0d pc", i),         32'(bus.pc),         vecs[i].e_pc);
      check($sformatf("v%0d mem_addr", i),   32'(bus.mem_addr),   vecs[i].e_addr);
      check($sformatf("v%0d mem_rd", i),     32'(bus.mem_rd),     vecs[i].e_rd);
      check($sformatf("v%0d mem_wr", i),     32'(bus.mem_wr),     vecs[i].e_wr);
      check($sformatf("v%0d fetch_busy", i), 32'(bus.fetch_busy), vecs[i].e_busy);
      check($sformatf("v%0d fetch_done", i), 32'(bus.fetch_done), vecs[i].e_done);
      check($sformatf("v%0d fetch_err", i),  32'(bus.fetch_err),  vecs[i].e_err);
      check($sformatf("v%0d ir_inst", i),    32'(bus.ir_inst),    vecs[i].e_ir);
    end

    // ir_load held high for 50 cycles, mem_ready in the 4th WAIT cycle (pc = 0x10).
    @(negedge clk);
    clear_inputs();
    step();
    done_cnt = 0;
    done_k   = -1;
    ir_chg   = 0;
    prev_ir  = bus.ir_inst;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      bus.ir_load   = 1'b1;
      bus.mem_ready = (k == 5);
      step();
      if (bus.fetch_done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (bus.ir_inst != prev_ir) begin
        ir_chg++;
        prev_ir = bus.ir_inst;
      end
    end
    check("held done count", 32'(done_cnt), 1);
    check("held done cycle", 32'(done_k), 5);
    check("held ir_inst", 32'(bus.ir_inst), 'hBEEF);
    check("held ir changes", 32'(ir_chg), 1);
    check("held busy", 32'(bus.fetch_busy), 0);

    // mem_ready arriving on the 15th WAIT cycle must still capture.
    @(negedge clk);
    clear_inputs();
    bus.pc_load      = 1'b1;
    bus.pc_load_addr = 8'h22;
    step();
    done_k = -1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      bus.pc_load   = 1'b0;
      bus.ir_load   = 1'b1;
      bus.mem_ready = (k == 16);
      step();
      if (bus.fetch_done && done_k < 0) done_k = k;
    end
    check("last-wait done cycle", 32'(done_k), 16);
    check("last-wait no fault", 32'(bus.fetch_err), 0);
    check("last-wait ir_inst", 32'(bus.ir_inst), 'h5A5A);

    // mem_ready never arrives: fault after 15 WAIT cycles, ir_inst untouched.
    @(negedge clk);
    clear_inputs();
    step();
    err_k  = -1;
    idle_k = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bus.ir_load = 1'b1;
      step();
      if (bus.fetch_err && err_k < 0) err_k = k;
      if (err_k >= 0 && !bus.fetch_busy && idle_k < 0) idle_k = k;
    end
    check("timeout err cycle", 32'(err_k), 16);
    check("timeout idle cycle", 32'(idle_k), 17);
    check("timeout ir_inst", 32'(bus.ir_inst), 'h5A5A);
    check("timeout busy", 32'(bus.fetch_busy), 0);
    @(negedge clk);
    clear_inputs();
    bus.pc_clear = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("err sticky", 32'(bus.fetch_err), 1);

    // Reset clears the fault; then reset in WAIT aborts the fetch.
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    step();
    check("rst err", 32'(bus.fetch_err), 0);
    check("rst pc", 32'(bus.pc), 0);
    check("rst ir_inst", 32'(bus.ir_inst), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    @(negedge clk);
    bus.ir_load = 1'b1;
    step();
    check("abort req busy", 32'(bus.fetch_busy), 1);
    step();
    @(negedge clk);
    rst = 1'b1;
    step();
    check("abort mem_rd", 32'(bus.mem_rd), 0);
    check("abort busy", 32'(bus.fetch_busy), 0);
    check("abort ir_inst", 32'(bus.ir_inst), 0);
    @(negedge clk);
    rst           = 1'b0;
    bus.mem_ready = 1'b1;
    step();
    check("late ready done", 32'(bus.fetch_done), 0);
    check("late ready ir_inst", 32'(bus.ir_inst), 0);
    check("held ir_load after rst", 32'(bus.fetch_busy), 1);
    step();
    check("refetch wait done", 32'(bus.fetch_done), 0);
    step();
    check("refetch done", 32'(bus.fetch_done), 1);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    step();
    check("refetch ir_inst", 32'(bus.ir_inst), 'h8105);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
